pps_phase_meas: RTL

Measures the signed time offset between the GPS 1PPS and the locally divided 1PPS in CLK_SYS cycles, one measurement per second. Sits downstream of the local 1PPS divider and upstream of the OCXO control loop (DAC/PI filter), which consumes PHASE_ERR on each PHASE_VLD pulse. Both pulse inputs are raw, asynchronous pins or divider outputs and are synchronised internally.

---
 rtl/pps_pkg.sv | 19 +
 rtl/pps_edge_sync.sv | 36 +++
 rtl/pps_phase_meas.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pps_pkg.sv
// Shared types and constants for the 1PPS phase measurement block.
package pps_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_LOCAL = 2'd1,
        WAIT_GPS   = 2'd2,
        REPORT     = 2'd3
    } pps_state_e;

    localparam int DEF_WINDOW = 5_000_000;
    localparam int DEF_CNT_W  = 24;

    // PHASE_ERR carries one sign bit on top of the counter magnitude.
    function automatic int err_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchroniser for an asynchronous pulse input, followed by a
// registered one-cycle rising-edge flag (3 cycles from pin to flag).
module pps_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1_q, sync2_q, dly_q, rise_q;
    logic sync1_d, sync2_d, dly_d, rise_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        rise_d  = sync2_q & ~dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pps_phase_meas.sv
// Signed GPS-to-local 1PPS offset in CLK_SYS cycles (local minus GPS).
// Define PHASE_AVG_EN to report the mean of 2^AVG_SHIFT results instead of each one.
module pps_phase_meas
    import pps_pkg::*;
#(
    parameter int WINDOW    = DEF_WINDOW,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int AVG_SHIFT = 3
) (
    input  logic                             CLK_SYS,
    input  logic                             CLK_RST,
    input  logic                             _1PPS_GPS,
    input  logic                             _1PPS_Local,
    input  logic                             MEAS_EN,
    output logic signed [err_w(CNT_W)-1:0]   PHASE_ERR,
    output logic                             PHASE_VLD,
    output logic                             TIMEOUT,
    output logic                             BUSY
);

    localparam int               ERR_W   = err_w(CNT_W);
    localparam logic [CNT_W-1:0] CNT_WIN = CNT_W'(WINDOW);

    // CLK_RST is expected to come from the system reset synchroniser.
    logic g, l;

    pps_edge_sync u_sync_gps (
        .clk  (CLK_SYS),
        .rst  (CLK_RST),
        .din  (_1PPS_GPS),
        .rise (g)
    );

    pps_edge_sync u_sync_local (
        .clk  (CLK_SYS),
        .rst  (CLK_RST),
        .din  (_1PPS_Local),
        .rise (l)
    );

    pps_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ERR_W-1:0] res_q, res_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic                    vld_q, vld_d;
    logic                    tmo_q, tmo_d;

`ifdef PHASE_AVG_EN
    localparam int ACC_W = ERR_W + AVG_SHIFT;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [AVG_SHIFT-1:0]    avg_cnt_q, avg_cnt_d;
    logic signed [ACC_W-1:0] avg_sum, avg_shr;
    logic signed [ERR_W-1:0] avg_out;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        tmo_d   = 1'b0;
        if (!MEAS_EN) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (g && l) begin
                        res_d   = '0;
                        state_d = REPORT;
                    end else if (g) begin
                        cnt_d   = CNT_W'(1);
                        state_d = WAIT_LOCAL;
                    end else if (l) begin
                        cnt_d   = CNT_W'(1);
                        state_d = WAIT_GPS;
                    end
                end
                WAIT_LOCAL: begin
                    // A closing edge on the last counted cycle still wins over timeout.
                    if (l) begin
                        res_d   = $signed({1'b0, cnt_q});
                        state_d = REPORT;
                    end else if (g) begin
                        tmo_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_WIN) begin
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_GPS: begin
                    if (g) begin
                        res_d   = -$signed({1'b0, cnt_q});
                        state_d = REPORT;
                    end else if (l) begin
                        tmo_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_WIN) begin
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPORT: begin
`ifdef PHASE_AVG_EN
                    if (avg_cnt_q == '1) begin
                        err_d = avg_out;
                        vld_d = 1'b1;
                    end
`else
                    err_d = res_q;
                    vld_d = 1'b1;
`endif
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PHASE_AVG_EN
    always_comb begin
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
        avg_sum   = acc_q + {{AVG_SHIFT{res_q[ERR_W-1]}}, res_q};
        avg_shr   = avg_sum >>> AVG_SHIFT;
        avg_out   = avg_shr[ERR_W-1:0];
        if (!MEAS_EN || tmo_d) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (state_q == REPORT) begin
            if (avg_cnt_q == '1) begin
                acc_d     = '0;
                avg_cnt_d = '0;
            end else begin
                acc_d     = avg_sum;
                avg_cnt_d = avg_cnt_q + AVG_SHIFT'(1);
            end
        end
    end

    always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
        if (CLK_RST) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`endif

    always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
        if (CLK_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
        end
    end

    assign PHASE_ERR = err_q;
    assign PHASE_VLD = vld_q;
    assign TIMEOUT   = tmo_q;
    assign BUSY      = (state_q != IDLE);

endmodule
